// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb
//   Round-robin burst arbiter that lets NREQ write requesters share a single
//   FIFO write port. An idle arbiter picks the next requester, searching
//   upward from the last burst owner with wrap-around. It then holds that
//   owner for a burst. The burst ends on a beat marked last, or once
//   MAX_BURST beats have been written.
//
// Optional feature (define FIFO_WR_ARB_STATS_EN):
//   Adds output beat_cnt. It holds one 16-bit saturating count of accepted
//   beats per requester.
//
// Ports
//   clock      rising-edge clock shared with the FIFO
//   rst        synchronous, active-high reset
//   req_valid  per-requester write request
//   req_data   per-requester data, requester n at [n*DW +: DW]
//   req_last   per-requester end-of-burst marker
//   req_ready  per-requester accept strobe (only the owner's bit can be high)
//   fifo_full  full flag from the FIFO
//   fifo_wr    FIFO write strobe
//   fifo_data  FIFO write data (0 when idle)
//   gnt_id     current owner index, meaningful while busy is high
//   busy       high while a burst is in progress
//   beat_cnt   per-requester accepted-beat counters (FIFO_WR_ARB_STATS_EN only)

module fifo_wr_arb #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned DW        = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                    clock,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*DW-1:0]      req_data,
    input  logic [NREQ-1:0]         req_last,
    output logic [NREQ-1:0]         req_ready,
    input  logic                    fifo_full,
    output logic                    fifo_wr,
    output logic [DW-1:0]           fifo_data,
    output logic [$clog2(NREQ)-1:0] gnt_id,
    output logic                    busy
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    output logic [NREQ*16-1:0]      beat_cnt
`endif
);

    localparam int unsigned IdW   = $clog2(NREQ);
    localparam int unsigned BeatW = $clog2(MAX_BURST + 1);

    typedef enum logic [0:0] {
        StIdle,
        StBurst
    } state_e;

    state_e           state_q, state_d;
    logic [IdW-1:0]   owner_q, owner_d;
    logic [IdW-1:0]   last_q, last_d;      // round-robin pointer
    logic [BeatW-1:0] beat_q, beat_d;

    logic             active;
    logic             xfer;
    logic             owner_valid;
    logic             owner_last;
    logic [BeatW-1:0] beat_inc;
    logic             pick_found;
    logic [IdW-1:0]   pick_id;
    logic [IdW-1:0]   scan_id;

    // ------------------------------------------------------------------
    // Round-robin search: first valid requester at or above last_q + 1,
    // wrapping, so last_q itself is checked last.
    // ------------------------------------------------------------------
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        scan_id    = '0;
        for (int i = 1; i <= int'(NREQ); i++) begin
            scan_id = IdW'((int'(last_q) + i) % int'(NREQ));
            if (!pick_found && req_valid[scan_id]) begin
                pick_found = 1'b1;
                pick_id    = scan_id;
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath and outputs
    // ------------------------------------------------------------------
    // Outputs are forced quiet while rst is high. This way a reset that
    // arrives mid-burst drops the write in that same cycle.
    assign active      = (state_q == StBurst) && !rst;
    assign owner_valid = req_valid[owner_q];
    assign owner_last  = req_last[owner_q];
    assign xfer        = active && owner_valid && !fifo_full;
    assign beat_inc    = beat_q + 1'b1;

    always_comb begin
        req_ready = '0;
        fifo_data = '0;
        if (active) begin
            req_ready[owner_q] = !fifo_full;
            fifo_data          = req_data[owner_q*DW +: DW];
        end
    end

    assign fifo_wr = xfer;
    assign busy    = active;
    assign gnt_id  = owner_q;

    // ------------------------------------------------------------------
    // FSM next-state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        beat_d  = beat_q;
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    state_d = StBurst;
                    owner_d = pick_id;
                    beat_d  = '0;
                end
            end
            StBurst: begin
                // Stalls (owner not valid, or FIFO full) leave all state alone.
                if (xfer) begin
                    beat_d = beat_inc;
                    if (owner_last || (beat_inc == BeatW'(MAX_BURST))) begin
                        state_d = StIdle;
                        last_d  = owner_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q <= StIdle;
            owner_q <= '0;
            last_q  <= IdW'(NREQ - 1);  // requester 0 wins first after reset
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
        end
    end

`ifdef FIFO_WR_ARB_STATS_EN
    // ------------------------------------------------------------------
    // Per-requester saturating beat counters
    // ------------------------------------------------------------------
    logic [15:0] cnt_q [NREQ];

    always_ff @(posedge clock) begin
        for (int i = 0; i < int'(NREQ); i++) begin
            if (rst) begin
                cnt_q[i] <= '0;
            end else if (xfer && (owner_q == IdW'(i)) && (cnt_q[i] != 16'hFFFF)) begin
                cnt_q[i] <= cnt_q[i] + 16'd1;
            end
        end
    end

    always_comb begin
        beat_cnt = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            beat_cnt[i*16 +: 16] = cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Self-checking bench for fifo_wr_arb: directed scenarios plus a randomized
// run against a cycle-level reference model of the arbitration rules.

module tb_fifo_wr_arb;

    localparam int NREQ      = 4;
    localparam int DW        = 8;
    localparam int MAX_BURST = 4;

    logic                clock = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*DW-1:0]  req_data;
    logic [NREQ-1:0]     req_last;
    logic [NREQ-1:0]     req_ready;
    logic                fifo_full;
    logic                fifo_wr;
    logic [DW-1:0]       fifo_data;
    logic [1:0]          gnt_id;
    logic                busy;
`ifdef FIFO_WR_ARB_STATS_EN
    logic [NREQ*16-1:0]  beat_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    fifo_wr_arb #(
        .NREQ      (NREQ),
        .DW        (DW),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clock     (clock),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .fifo_full (fifo_full),
        .fifo_wr   (fifo_wr),
        .fifo_data (fifo_data),
        .gnt_id    (gnt_id),
        .busy      (busy)
`ifdef FIFO_WR_ARB_STATS_EN
        ,
        .beat_cnt  (beat_cnt)
`endif
    );

    always #5 clock = ~clock;

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_data(input int n, input logic [7:0] v);
        req_data[n*DW +: DW] = v;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Reference model: burst ownership expressed as plain integers
    // ------------------------------------------------------------------
    bit m_busy;
    int m_owner;
    int m_last;
    int m_beats;
    int m_cnt [NREQ];

    function automatic int pick_next(input logic [NREQ-1:0] v, input int last);
        for (int i = 1; i <= NREQ; i++) begin
            if (v[(last + i) % NREQ]) return (last + i) % NREQ;
        end
        return -1;
    endfunction

    // Advance the model by one clock edge, using the inputs present at that edge.
    function automatic void model_step();
        int nxt;
        if (rst) begin
            m_busy  = 0;
            m_owner = 0;
            m_last  = NREQ - 1;
            m_beats = 0;
            for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
        end else if (!m_busy) begin
            nxt = pick_next(req_valid, m_last);
            if (nxt >= 0) begin
                m_busy  = 1;
                m_owner = nxt;
                m_beats = 0;
            end
        end else if (req_valid[m_owner] && !fifo_full) begin
            m_beats++;
            if (m_cnt[m_owner] < 65535) m_cnt[m_owner]++;
            if (req_last[m_owner] || m_beats == MAX_BURST) begin
                m_busy = 0;
                m_last = m_owner;
            end
        end
    endfunction

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 4'b1111;
        req_last  = 4'b0000;
        req_data  = 32'hDEADBEEF;
        fifo_full = 1'b0;
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b want 0", busy); end
        n_cmp++; if (fifo_wr !== 1'b0) begin n_err++; $display("FAIL reset_wr: got %0b want 0", fifo_wr); end
        n_cmp++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
        n_cmp++; if (fifo_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", fifo_data); end
        n_cmp++; if (gnt_id !== 2'd0) begin n_err++; $display("FAIL reset_gnt: got %0d want 0", gnt_id); end
        rst       = 1'b0;
        req_valid = '0;
        #1;
        n_cmp++; if (busy !== 1'b0 || fifo_wr !== 1'b0) begin n_err++; $display("FAIL post_reset_idle: busy %0b wr %0b want 0 0", busy, fifo_wr); end
`ifdef FIFO_WR_ARB_STATS_EN
        n_cmp++; if (beat_cnt !== '0) begin n_err++; $display("FAIL reset_stats: got %h want 0", beat_cnt); end
`endif
    endtask

    task automatic test_single_burst();
        logic [7:0] bytes [3];
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
        do_reset();
        req_valid = 4'b0001;
        set_data(0, bytes[0]);
        #1;
        n_cmp++; if (busy !== 1'b0 || fifo_wr !== 1'b0) begin n_err++; $display("FAIL single_idle: busy %0b wr %0b want 0 0", busy, fifo_wr); end
        tick();
        for (int b = 0; b < 3; b++) begin
            set_data(0, bytes[b]);
            req_last = (b == 2) ? 4'b0001 : 4'b0000;
            #1;
            n_cmp++; if (busy !== 1'b1 || gnt_id !== 2'd0) begin n_err++; $display("FAIL single_busy%0d: busy %0b gnt %0d want 1 0", b, busy, gnt_id); end
            n_cmp++; if (fifo_wr !== 1'b1 || fifo_data !== bytes[b]) begin n_err++; $display("FAIL single_beat%0d: wr %0b data %h want 1 %h", b, fifo_wr, fifo_data, bytes[b]); end
            tick();
        end
        req_valid = '0;
        req_last  = '0;
        #1;
        n_cmp++; if (busy !== 1'b0 || fifo_wr !== 1'b0) begin n_err++; $display("FAIL single_end: busy %0b wr %0b want 0 0", busy, fifo_wr); end
    endtask

    task automatic test_round_robin();
        int order [5];
        order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;
        do_reset();
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        for (int n = 0; n < NREQ; n++) set_data(n, 8'(8'hA0 + n));
        for (int k = 0; k < 10; k++) begin
            #1;
            if (k % 2 == 0) begin
                n_cmp++; if (busy !== 1'b0 || fifo_wr !== 1'b0) begin n_err++; $display("FAIL rr_idle%0d: busy %0b wr %0b want 0 0", k, busy, fifo_wr); end
            end else begin
                n_cmp++; if (busy !== 1'b1 || gnt_id !== 2'(order[k/2])) begin n_err++; $display("FAIL rr_grant%0d: busy %0b gnt %0d want 1 %0d", k, busy, gnt_id, order[k/2]); end
                n_cmp++; if (fifo_wr !== 1'b1 || fifo_data !== 8'(8'hA0 + order[k/2])) begin n_err++; $display("FAIL rr_data%0d: wr %0b data %h want 1 %h", k, fifo_wr, fifo_data, 8'(8'hA0 + order[k/2])); end
            end
            tick();
        end
        req_valid = '0;
        req_last  = '0;
    endtask

    task automatic test_max_burst();
        do_reset();
        req_valid = 4'b0100;
        set_data(2, 8'h21);
        tick();
        // Requester 0 becomes valid mid-burst; it must wait for the burst cap.
        req_valid = 4'b0101;
        req_last  = 4'b0001;
        set_data(0, 8'h0F);
        for (int b = 0; b < MAX_BURST; b++) begin
            #1;
            n_cmp++; if (busy !== 1'b1 || gnt_id !== 2'd2) begin n_err++; $display("FAIL max_owner%0d: busy %0b gnt %0d want 1 2", b, busy, gnt_id); end
            n_cmp++; if (fifo_wr !== 1'b1 || fifo_data !== 8'(8'h21 + b)) begin n_err++; $display("FAIL max_beat%0d: wr %0b data %h want 1 %h", b, fifo_wr, fifo_data, 8'(8'h21 + b)); end
            n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL max_ready%0d: got %b want 0100", b, req_ready); end
            tick();
            set_data(2, 8'(8'h22 + b));
        end
        #1;
        n_cmp++; if (busy !== 1'b0 || fifo_wr !== 1'b0) begin n_err++; $display("FAIL max_capped: busy %0b wr %0b want 0 0", busy, fifo_wr); end
        tick();
        n_cmp++; if (busy !== 1'b1 || gnt_id !== 2'd0 || fifo_data !== 8'h0F) begin n_err++; $display("FAIL max_other: busy %0b gnt %0d data %h want 1 0 0f", busy, gnt_id, fifo_data); end
        tick();
        req_valid = 4'b0100;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL max_gap: busy %0b want 0", busy); end
        tick();
        n_cmp++; if (busy !== 1'b1 || gnt_id !== 2'd2 || fifo_data !== 8'h25) begin n_err++; $display("FAIL max_regrant: busy %0b gnt %0d data %h want 1 2 25", busy, gnt_id, fifo_data); end
        req_valid = '0;
        req_last  = '0;
    endtask

    task automatic test_full_stall();
        do_reset();
        req_valid = 4'b0010;
        set_data(1, 8'h51);
        tick();
        #1;
        n_cmp++; if (fifo_wr !== 1'b1 || fifo_data !== 8'h51 || gnt_id !== 2'd1) begin n_err++; $display("FAIL full_first: wr %0b data %h gnt %0d want 1 51 1", fifo_wr, fifo_data, gnt_id); end
        tick();
        set_data(1, 8'h52);
        fifo_full = 1'b1;
        for (int s = 0; s < 3; s++) begin
            #1;
            n_cmp++; if (fifo_wr !== 1'b0 || req_ready !== 4'b0) begin n_err++; $display("FAIL full_stall%0d: wr %0b ready %b want 0 0000", s, fifo_wr, req_ready); end
            n_cmp++; if (busy !== 1'b1 || gnt_id !== 2'd1) begin n_err++; $display("FAIL full_owner%0d: busy %0b gnt %0d want 1 1", s, busy, gnt_id); end
            tick();
        end
        fifo_full = 1'b0;
        for (int b = 0; b < 3; b++) begin
            #1;
            n_cmp++; if (fifo_wr !== 1'b1 || fifo_data !== 8'(8'h52 + b)) begin n_err++; $display("FAIL full_resume%0d: wr %0b data %h want 1 %h", b, fifo_wr, fifo_data, 8'(8'h52 + b)); end
            tick();
            set_data(1, 8'(8'h53 + b));
        end
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL full_end: busy %0b want 0", busy); end
        req_valid = '0;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        // One-beat burst on requester 1 moves the round-robin pointer to 1.
        req_valid = 4'b0010;
        req_last  = 4'b0010;
        set_data(1, 8'h61);
        tick();
        tick();
        req_valid = 4'b0100;
        req_last  = 4'b0000;
        set_data(2, 8'h71);
        tick();
        #1;
        n_cmp++; if (fifo_wr !== 1'b1 || gnt_id !== 2'd2) begin n_err++; $display("FAIL rmid_first: wr %0b gnt %0d want 1 2", fifo_wr, gnt_id); end
        tick();
        set_data(2, 8'h72);
        rst = 1'b1;
        #1;
        n_cmp++; if (fifo_wr !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rmid_during: wr %0b busy %0b want 0 0", fifo_wr, busy); end
        tick();
        rst       = 1'b0;
        req_valid = 4'b1111;
        #1;
        n_cmp++; if (busy !== 1'b0 || fifo_wr !== 1'b0 || req_ready !== 4'b0 || fifo_data !== 8'h00) begin n_err++; $display("FAIL rmid_after: busy %0b wr %0b ready %b data %h want 0 0 0000 00", busy, fifo_wr, req_ready, fifo_data); end
`ifdef FIFO_WR_ARB_STATS_EN
        n_cmp++; if (beat_cnt !== '0) begin n_err++; $display("FAIL rmid_stats: got %h want 0", beat_cnt); end
`endif
        tick();
        n_cmp++; if (busy !== 1'b1 || gnt_id !== 2'd0) begin n_err++; $display("FAIL rmid_regrant: busy %0b gnt %0d want 1 0", busy, gnt_id); end
        req_valid = '0;
    endtask

    task automatic test_random();
        logic            e_busy;
        logic            e_wr;
        logic [NREQ-1:0] e_ready;
        logic [DW-1:0]   e_data;
        do_reset();
        rst = 1'b1;
        model_step();
        rst = 1'b0;
        for (int c = 0; c < 600; c++) begin
            req_valid = NREQ'($urandom);
            for (int n = 0; n < NREQ; n++) req_last[n] = ($urandom_range(0, 2) == 0);
            req_data  = 32'($urandom);
            fifo_full = ($urandom_range(0, 4) == 0);
            rst       = ($urandom_range(0, 96) == 0);
            #1;
            e_busy  = m_busy && !rst;
            e_wr    = e_busy && req_valid[m_owner] && !fifo_full;
            e_ready = (e_busy && !fifo_full) ? NREQ'(1 << m_owner) : '0;
            e_data  = e_busy ? req_data[m_owner*DW +: DW] : '0;
            n_cmp++; if (busy !== e_busy) begin n_err++; $display("FAIL rnd_busy c%0d: got %0b want %0b", c, busy, e_busy); end
            n_cmp++; if (fifo_wr !== e_wr) begin n_err++; $display("FAIL rnd_wr c%0d: got %0b want %0b", c, fifo_wr, e_wr); end
            n_cmp++; if (req_ready !== e_ready) begin n_err++; $display("FAIL rnd_ready c%0d: got %b want %b", c, req_ready, e_ready); end
            n_cmp++; if (fifo_data !== e_data) begin n_err++; $display("FAIL rnd_data c%0d: got %h want %h", c, fifo_data, e_data); end
            if (e_busy) begin
                n_cmp++; if (gnt_id !== 2'(m_owner)) begin n_err++; $display("FAIL rnd_gnt c%0d: got %0d want %0d", c, gnt_id, m_owner); end
            end
`ifdef FIFO_WR_ARB_STATS_EN
            for (int n = 0; n < NREQ; n++) begin
                n_cmp++; if (beat_cnt[n*16 +: 16] !== 16'(m_cnt[n])) begin n_err++; $display("FAIL rnd_stats%0d c%0d: got %0d want %0d", n, c, beat_cnt[n*16 +: 16], m_cnt[n]); end
            end
`endif
            @(posedge clock);
            model_step();
            #1;
        end
        rst       = 1'b0;
        req_valid = '0;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        test_reset();
        test_single_burst();
        test_round_robin();
        test_max_burst();
        test_full_stall();
        test_reset_mid_burst();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
